// File: rtl/mips_store_buffer.sv
// In-order store buffer between the MEM stage and data memory.
// Forwards youngest matching store to loads; fence drains all entries.
module mips_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [31:0]            st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_hit,
    output logic [31:0]            ld_data,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ready,
    input  logic                   fence,
    output logic                   fence_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic            push, pop;
    logic [PW-1:0]   idx;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign st_ready = !full && (state_q == IDLE);
    assign push     = st_valid && st_ready;
    assign pop      = !empty && mem_ready;

    // Drain port shows zeros when nothing is queued
    assign mem_we    = !empty;
    assign mem_addr  = empty ? '0 : addr_q[rd_ptr_q];
    assign mem_wdata = empty ? '0 : data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        fence_done = 1'b0;
        unique case (state_q)
            IDLE:    if (fence) state_d = empty ? DONE : DRAIN;
            DRAIN:   if (count_d == '0) state_d = DONE;
            DONE: begin
                fence_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan oldest to youngest so the last match wins
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (ld_valid && (CW'(k) < count_q) && (addr_q[idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
        end
    end

endmodule
